delay_int16_elastic: RTL and testbench

- Stallable counterpart of the fixed-latency INT16 delay line. Inserts a DEPTH-cycle delay on a valid/ready stream and honours backpressure from the consumer without losing or duplicating samples.
- Placed by the HLS scheduler where a balancing delay feeds a consumer that can stall, such as an output port or a shared operator.

---
 rtl/delay_int16_elastic_pkg.sv | 13 +
 rtl/delay_stage_elastic.sv | 33 +++
 rtl/delay_int16_elastic.sv | 84 ++++++++
 tb/tb_delay_int16_elastic.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/delay_int16_elastic_pkg.sv
// Shared definitions for the stallable INT16 delay line: default word width,
// sample type and the occupancy counter width helper.
package delay_int16_elastic_pkg;

    localparam int unsigned WIDTH_DEF = 16;

    typedef logic [WIDTH_DEF-1:0] sample_t;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_stage_elastic.sv
// One elastic slice: a data/valid register pair that loads when its advance
// enable is high and holds otherwise.
module delay_stage_elastic
    import delay_int16_elastic_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] d_o,
    output logic             v_o
);

    logic [WIDTH-1:0] d_q;
    logic             v_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else if (adv_i) begin
            d_q <= d_i;
            v_q <= v_i;
        end
    end

    assign d_o = d_q;
    assign v_o = v_q;

endmodule

// File: rtl/delay_int16_elastic.sv
// DEPTH-stage delay line on a valid/ready stream; empty stages keep filling
// under stall, so up to DEPTH samples are held without loss or duplication.
module delay_int16_elastic
    import delay_int16_elastic_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] src_d;
        logic             src_v;

        if (i == 0) begin : g_head
            assign src_d = in;
            assign src_v = in_valid;
        end else begin : g_body
            assign src_d = d[i-1];
            assign src_v = v[i-1];
        end

        // Unrolled advance chain: a stage may move if any stage at or below it
        // is empty, or the consumer takes the last one.
        assign adv[i] = out_ready | ~(&v[DEPTH-1:i]);

        delay_stage_elastic #(.WIDTH(WIDTH)) u_stage (
            .clk_i   (clock),
            .rst_n_i (reset),
            .adv_i   (adv[i]),
            .d_i     (src_d),
            .v_i     (src_v),
            .d_o     (d[i]),
            .v_o     (v[i])
        );
    end

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; in_ready is combinational in out_ready by design.
    assign in_ready  = adv[0];
    assign out       = d[DEPTH-1];
    assign out_valid = v[DEPTH-1];
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        case ({in_xfer, out_xfer})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

endmodule

// File: tb/tb_delay_int16_elastic.sv
// Directed and random checks of the stallable INT16 delay line against
// hand-computed vectors and a FIFO scoreboard.
module tb_delay_int16_elastic;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       occupancy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] exp_q[$];

    delay_int16_elastic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in        (in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic             prev_stall;
        logic [WIDTH-1:0] prev_out;
        logic             exp_ready;

        reset     = 1'b0;
        in        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out", out, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_occ", occupancy, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // single sample: visible DEPTH-1 edges after acceptance, for one cycle
        in       = 16'h1234;
        in_valid = 1'b1;
        #1;
        check("t1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("t1_occ_accept", occupancy, 1);
        check("t1_ov_accept", out_valid, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t1_out_valid", out_valid, (i == 3));
            if (i == 3) check("t1_out", out, 16'h1234);
            check("t1_occ", occupancy, (i <= 3) ? 1 : 0);
        end

        // continuous stream with consumer always ready
        for (int t = 1; t <= 12; t++) begin
            in       = WIDTH'(t - 1);
            in_valid = 1'b1;
            #1;
            check("t2_in_ready", in_ready, 1);
            tick();
            check("t2_occ", occupancy, (t < 4) ? t : 4);
            check("t2_out_valid", out_valid, (t >= 4));
            if (t >= 4) check("t2_out", out, t - 4);
        end
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t2_drain_occ", occupancy, 4 - k);
            check("t2_drain_ov", out_valid, (k < 4));
            if (k < 4) check("t2_drain_out", out, 8 + k);
        end

        // stall: fill all stages, then hold
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            in       = 16'hA000 + WIDTH'(j);
            in_valid = 1'b1;
            #1;
            check("t3_in_ready_fill", in_ready, 1);
            tick();
        end
        check("t3_full_occ", occupancy, 4);
        check("t3_full_ov", out_valid, 1);
        check("t3_full_out", out, 16'hA000);
        in = 16'hA004;
        #1;
        check("t3_in_ready_full", in_ready, 0);
        tick();
        check("t3_hold_occ", occupancy, 4);
        check("t3_hold_out", out, 16'hA000);
        in_valid = 1'b0;
        #1;
        check("t3_in_ready_drop", in_ready, 0);
        tick();
        check("t3_hold2_occ", occupancy, 4);
        check("t3_hold2_ov", out_valid, 1);
        check("t3_hold2_out", out, 16'hA000);

        // full with both sides ready: one in, one out, occupancy unchanged
        in        = 16'hA004;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t4_in_ready", in_ready, 1);
        tick();
        check("t4_occ", occupancy, 4);
        check("t4_out", out, 16'hA001);
        in = 16'hA005;
        tick();
        check("t4_occ2", occupancy, 4);
        check("t4_out2", out, 16'hA002);
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t4_drain_occ", occupancy, 4 - k);
            check("t4_drain_ov", out_valid, (k < 4));
            if (k < 4) check("t4_drain_out", out, 16'hA002 + k);
        end

        // reset mid-stream with three samples held
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in       = 16'hB000 + WIDTH'(j);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("t5_occ_before", occupancy, 3);
        #2;
        reset = 1'b0;
        #1;
        check("t5_rst_ov", out_valid, 0);
        check("t5_rst_occ", occupancy, 0);
        check("t5_rst_out", out, 0);
        check("t5_rst_in_ready", in_ready, 1);
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t5_post_ov", out_valid, 0);
            check("t5_post_occ", occupancy, 0);
        end

        // random traffic against the scoreboard, then a drain phase
        exp_q.delete();
        prev_stall = 1'b0;
        prev_out   = '0;
        for (int c = 0; c < 3100; c++) begin
            if (c < 3000) begin
                in_valid  = ($urandom_range(0, 99) < 70);
                in        = WIDTH'($urandom_range(0, 65535));
                out_ready = ($urandom_range(0, 99) < ((c < 1500) ? 40 : 80));
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            exp_ready = (exp_q.size() < DEPTH) || out_ready;
            check("rnd_occ", occupancy, exp_q.size());
            check("rnd_in_ready", in_ready, exp_ready);
            if (prev_stall) begin
                check("rnd_stall_ov", out_valid, 1);
                check("rnd_stall_out", out, prev_out);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) check("rnd_spurious", out_valid, 0);
                else check("rnd_data", out, exp_q[0]);
            end
            if (in_valid && exp_ready) exp_q.push_back(in);
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            prev_stall = out_valid && !out_ready;
            prev_out   = out;
            tick();
        end
        check("rnd_final_queue", exp_q.size(), 0);
        check("rnd_final_occ", occupancy, 0);
        check("rnd_final_ov", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
